// File: rtl/shift_add_mult_controller.sv
// Control FSM for a shift-add sequential multiplier: sequences load, shift and
// add_shift strobes, counts iterations and pulses done on completion.
module shift_add_mult_controller #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mplier_lsb,
  input  logic                   mplier_zero,
  output logic                   load,
  output logic                   shift,
  output logic                   add_shift,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(WIDTH):0] iter_count
);

  localparam int unsigned   CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Three-bit encoding leaves spare codes so a corrupted state can recover.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    DONE = 3'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    shift     = 1'b0;
    add_shift = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          count_d = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (EARLY_EXIT && mplier_zero) begin
          state_d = DONE;
        end else begin
          if (mplier_lsb) add_shift = 1'b1;
          else            shift     = 1'b1;
          if (count_q < CNT_MAX)   count_d = count_q + CW'(1);
          if (count_q >= CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign iter_count = count_q;

endmodule

// File: tb/tb_shift_add_mult_controller.sv
// Bench for shift_add_mult_controller: two instances (EARLY_EXIT 0 and 1), each
// closed around a multiplier shift-register model, checked against a scoreboard.
module tb_shift_add_mult_controller;

  typedef enum logic [1:0] {K_LOAD, K_SHIFT, K_ADD, K_DONE} kind_e;
  typedef struct packed {
    kind_e      kind;
    logic [4:0] cnt;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] opnd;
  logic [1:0]  lsb, zero, ld, sh, ad, bz, dn;
  logic [4:0]  ic0, ic1;
  logic [15:0] m0, m1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_cyc[2];
  int load_cyc[2];
  int ndone[2];
  ev_t q0[$];
  ev_t q1[$];

  shift_add_mult_controller #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mplier_lsb(lsb[0]), .mplier_zero(zero[0]),
    .load(ld[0]), .shift(sh[0]), .add_shift(ad[0]), .busy(bz[0]), .done(dn[0]),
    .iter_count(ic0)
  );

  shift_add_mult_controller #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mplier_lsb(lsb[1]), .mplier_zero(zero[1]),
    .load(ld[1]), .shift(sh[1]), .add_shift(ad[1]), .busy(bz[1]), .done(dn[1]),
    .iter_count(ic1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier shift register driven by the controller strobes
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      if (ld[0]) m0 <= opnd;
      else if (sh[0] | ad[0]) m0 <= m0 >> 1;
      if (ld[1]) m1 <= opnd;
      else if (sh[1] | ad[1]) m1 <= m1 >> 1;
    end
  end
  assign lsb  = {m1[0], m0[0]};
  assign zero = {(m1 == 16'd0), (m0 == 16'd0)};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int u, input ev_t e);
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected event stream for one operation; dc = expected done cycle, ns = strobes.
  task automatic push_op(input int u, input logic [15:0] op, input bit early,
                         input int max_str, input bit with_done,
                         output int dc, output int ns);
    ev_t e;
    logic [15:0] r;
    r = op;
    ns = 0;
    e.kind = K_LOAD;
    e.cnt = '0;
    push_ev(u, e);
    for (int i = 0; i < 16 && i < max_str; i++) begin
      if (early && r == 16'd0) break;
      e.kind = r[0] ? K_ADD : K_SHIFT;
      push_ev(u, e);
      r = r >> 1;
      ns++;
    end
    if (with_done) begin
      e.kind = K_DONE;
      e.cnt = 5'(ns);
      push_ev(u, e);
    end
    dc = (ns == 16) ? 18 : ns + 3;
  endtask

  task automatic check_unit(input int u);
    logic l, s, a, d, have;
    logic [4:0] c;
    kind_e k;
    ev_t e;
    l = ld[u]; s = sh[u]; a = ad[u]; d = dn[u];
    c = (u == 0) ? ic0 : ic1;
    chk($sformatf("u%0d_excl_c%0d", u, cyc), 32'(s & a), 32'd0);
    if (l | s | a | d) begin
      k = l ? K_LOAD : d ? K_DONE : a ? K_ADD : K_SHIFT;
      have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
      chk($sformatf("u%0d_expected_event_c%0d", u, cyc), 32'(have), 32'd1);
      if (have) begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("u%0d_kind_c%0d", u, cyc), 32'(k), 32'(e.kind));
        if (k == K_DONE) begin
          chk($sformatf("u%0d_iter_c%0d", u, cyc), 32'(c), 32'(e.cnt));
          done_cyc[u] = cyc;
          ndone[u]++;
        end
        if (k == K_LOAD) load_cyc[u] = cyc;
      end
    end
  endtask

  // Check the current cycle at the falling edge, then advance one cycle.
  task automatic step();
    @(negedge clk);
    check_unit(0);
    check_unit(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while ((bz != 2'b00 || dn != 2'b00) && n < 60) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] op);
    int dc0, dc1, ns0, ns1;
    opnd = op;
    push_op(0, op, 1'b0, 16, 1'b1, dc0, ns0);
    push_op(1, op, 1'b1, 16, 1'b1, dc1, ns1);
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    run_idle();
    chk({tag, "_u0_done_cyc"}, 32'(done_cyc[0]), 32'(dc0));
    chk({tag, "_u1_done_cyc"}, 32'(done_cyc[1]), 32'(dc1));
    chk({tag, "_u0_iter_hold"}, 32'(ic0), 32'(ns0));
    chk({tag, "_u1_iter_hold"}, 32'(ic1), 32'(ns1));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_u0_outs"}, 32'({ld[0], sh[0], ad[0], bz[0], dn[0]}), 32'd0);
    chk({tag, "_u1_outs"}, 32'({ld[1], sh[1], ad[1], bz[1], dn[1]}), 32'd0);
  endtask

  initial begin
    int dc, ns, nd0, nd1;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    opnd  = '0;
    ndone[0] = 0;
    ndone[1] = 0;
    #3;
    chk_quiet("reset");
    chk("reset_u0_iter", 32'(ic0), 32'd0);
    chk("reset_u1_iter", 32'(ic1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_op("op0005", 16'h0005);
    chk("op0005_u0_iter16", 32'(ic0), 32'd16);
    chk("op0005_u1_iter3", 32'(ic1), 32'd3);
    chk("op0005_u1_done6", 32'(done_cyc[1]), 32'd6);
    do_op("opFFFF", 16'hFFFF);
    do_op("op0000", 16'h0000);
    chk("op0000_u1_done3", 32'(done_cyc[1]), 32'd3);

    // start held high across a whole operation and into the next
    opnd = 16'h8001;
    push_op(0, opnd, 1'b0, 16, 1'b1, dc, ns);
    push_op(1, opnd, 1'b1, 16, 1'b1, dc, ns);
    push_op(0, opnd, 1'b0, 16, 1'b1, dc, ns);
    push_op(1, opnd, 1'b1, 16, 1'b1, dc, ns);
    nd0 = ndone[0];
    nd1 = ndone[1];
    cyc = 0;
    start = 1'b1;
    for (int i = 0; i < 40 && (ndone[0] == nd0 || ndone[1] == nd1); i++) step();
    chk("held_u0_done18", 32'(done_cyc[0]), 32'd18);
    chk("held_u1_done18", 32'(done_cyc[1]), 32'd18);
    step();
    step();
    chk("held_u0_reload20", 32'(load_cyc[0]), 32'd20);
    chk("held_u1_reload20", 32'(load_cyc[1]), 32'd20);
    start = 1'b0;
    run_idle();
    chk("held_u0_two_dones", 32'(ndone[0] - nd0), 32'd2);
    chk("held_u1_two_dones", 32'(ndone[1] - nd1), 32'd2);

    // abort during EXEC cycle 5 (three strobes already issued)
    opnd = 16'h00F3;
    push_op(0, opnd, 1'b0, 3, 1'b0, dc, ns);
    push_op(1, opnd, 1'b1, 3, 1'b0, dc, ns);
    nd0 = ndone[0];
    nd1 = ndone[1];
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    #1;
    chk("abort_strobes_low", 32'({sh, ad}), 32'd0);
    chk("abort_busy_in_cycle", 32'(bz), 32'd3);
    step();
    abort = 1'b0;
    chk("abort_idle_next", 32'(bz), 32'd0);
    chk("abort_u0_iter_hold", 32'(ic0), 32'd3);
    chk("abort_u1_iter_hold", 32'(ic1), 32'd3);
    repeat (3) step();
    chk("abort_no_done", 32'((ndone[0] - nd0) + (ndone[1] - nd1)), 32'd0);

    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_quiet("abort_start_idle");
    step();

    // asynchronous reset in the middle of EXEC
    opnd = 16'hFFFF;
    push_op(0, opnd, 1'b0, 16, 1'b1, dc, ns);
    push_op(1, opnd, 1'b1, 16, 1'b1, dc, ns);
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("pre_reset_busy", 32'(bz), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_quiet("midreset");
    chk("midreset_u0_iter", 32'(ic0), 32'd0);
    chk("midreset_u1_iter", 32'(ic1), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_op("op0003", 16'h0003);

    chk("sb_u0_drained", 32'(q0.size()), 32'd0);
    chk("sb_u1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
